// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the data-memory access unit
package dmem_pkg;

    localparam int AW_DEF = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } state_t;

    typedef struct packed {
        logic [AW_DEF-1:0] idx;
        logic [31:0]       data;
    } sb_entry_t;

    // Byte address to SRAM word index; upper address bits alias onto the macro.
    function automatic logic [AW_DEF-1:0] word_idx(input logic [31:0] addr);
        return addr[AW_DEF+1:2];
    endfunction

endpackage

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - FIFO store buffer with youngest-match load lookup
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter  int SB_DEPTH = 2,
    localparam int PW       = $clog2(SB_DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  sb_entry_t         i_push_entry,
    input  logic              i_pop,
    output sb_entry_t         o_head,
    output logic [CW-1:0]     o_count,
    input  logic [AW_DEF-1:0] i_lookup_idx,
    output logic              o_hit,
    output logic [31:0]       o_hit_data
);

    sb_entry_t     r_mem [SB_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Storage is cleared on reset so the idle SRAM address/data read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_entry;
                r_tail        <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Walk from oldest to youngest so the last match found wins.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((CW'(i) < r_count) && (r_mem[r_head + PW'(i)].idx == i_lookup_idx)) begin
                o_hit      = 1'b1;
                o_hit_data = r_mem[r_head + PW'(i)].data;
            end
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - CPU load/store front end driving an active-low SRAM macro
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter  int AW       = AW_DEF,
    parameter  int SB_DEPTH = 2,
    localparam int CW       = $clog2(SB_DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [31:0]   i_req_addr,
    input  logic [31:0]   i_req_wdata,
    output logic          o_resp_valid,
    output logic [31:0]   o_resp_rdata,
    output logic          o_misalign,
    output logic          o_sb_empty,
    output logic          o_mem_cen,
    output logic          o_mem_wen,
    output logic          o_mem_oen,
    output logic [AW-1:0] o_mem_a,
    output logic [31:0]   o_mem_d,
    input  logic [31:0]   i_mem_q
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW_DEF-1:0] r_rd_idx;
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_misalign;

    logic              w_accept;
    logic              w_aligned;
    logic [AW_DEF-1:0] w_idx;
    logic              w_push;
    logic              w_drain;
    sb_entry_t         w_push_entry;
    sb_entry_t         w_head;
    logic [CW-1:0]     w_count;
    logic              w_hit;
    logic [31:0]       w_hit_data;

    assign o_req_ready  = !i_rst && (r_state == IDLE) && (w_count < CW'(SB_DEPTH));
    assign w_accept     = i_req_valid && o_req_ready;
    assign w_aligned    = (i_req_addr[1:0] == 2'b00);
    assign w_idx        = word_idx(i_req_addr);
    assign w_push       = w_accept && i_req_we && w_aligned;
    assign w_push_entry = '{idx: w_idx, data: i_req_wdata};
    // Accepted requests win the SRAM port; the buffer drains only in gaps.
    assign w_drain      = (r_state == IDLE) && (w_count != '0) && !w_accept;

    dmem_store_buffer #(
        .SB_DEPTH (SB_DEPTH)
    ) u_store_buffer (
        .clk          (i_clk),
        .rst          (i_rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_drain),
        .o_head       (w_head),
        .o_count      (w_count),
        .i_lookup_idx (w_idx),
        .o_hit        (w_hit),
        .o_hit_data   (w_hit_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !i_req_we && w_aligned && !w_hit) begin
                    w_state_nxt = RD;
                end
            end
            RD:      w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_idx     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_misalign   <= 1'b0;
            if (r_state == RD) begin
                r_resp_valid <= 1'b1;
                r_resp_rdata <= i_mem_q;
            end else if (w_accept) begin
                if (!w_aligned) begin
                    r_misalign <= 1'b1;
                    if (!i_req_we) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                    end
                end else if (!i_req_we) begin
                    if (w_hit) begin
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= w_hit_data;
                    end else begin
                        r_rd_idx <= w_idx;
                    end
                end
            end
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_misalign   = r_misalign;
    assign o_sb_empty   = (w_count == '0);
    assign o_mem_cen    = !((r_state == RD) || w_drain);
    assign o_mem_wen    = !w_drain;
    assign o_mem_oen    = 1'b0;
    assign o_mem_a      = (r_state == RD) ? AW'(r_rd_idx) : AW'(w_head.idx);
    assign o_mem_d      = w_head.data;

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store front end between the SingleCycle_MIPS datapath and the HSs18n_128x32 data SRAM macro. It turns CPU memory requests into active-low SRAM strobes over a valid/ready handshake. A small store buffer lets stores retire in one cycle, and loads that hit a buffered store are forwarded without an SRAM access. The SRAM clock is tied to ~clk at the top level, so the macro samples its inputs mid-cycle.

## Interface
- AW, 7: SRAM word-address width (128 words).
- SB_DEPTH, 2: store-buffer entries; power of two, ≥2.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  request accepted when valid&ready at posedge.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; word index = req_addr[AW+1:2].
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle pulse with load data.
- resp_rdata  out  32  load data, held until the next response.
- misalign  out  1  one-cycle pulse: accepted request had req_addr[1:0]≠0.
- sb_empty  out  1  store buffer empty.
- mem_cen  out  1  SRAM chip enable, active low.
- mem_wen  out  1  SRAM write enable, active low.
- mem_oen  out  1  SRAM output enable, active low; constant 0.
- mem_a  out  AW  SRAM word address.
- mem_d  out  32  SRAM write data.
- mem_q  in  32  SRAM read data; valid before the posedge following the sampling negedge.

## Operation
- **States:** IDLE and RD.
- **req_ready:** `= !rst && state==IDLE && count<SB_DEPTH`. The same condition applies to loads and stores.
- **Aligned store accepted:** pushed into the buffer FIFO (addr index, data). No response is generated.
- **Aligned load accepted:**
  - All valid buffer entries are compared on word index.
  - Hit: the youngest matching entry is returned. resp_rdata is registered at the accept edge and resp_valid is high the next cycle. State stays IDLE.
  - Miss: the word index is latched and the state goes to RD.
- **RD (exactly one cycle):**
  - mem_cen=0, mem_wen=1, mem_a=latched index.
  - At the next posedge: resp_rdata<=mem_q, resp_valid=1 for one cycle, state→IDLE.
- **Misaligned request:**
  - No buffer push and no SRAM access.
  - misalign=1 for one cycle after the accept edge.
  - A misaligned load also pulses resp_valid with resp_rdata=0.
- **Drain:**
  - Condition: state==IDLE && count>0 && !(req_valid&&req_ready).
  - Action: mem_cen=0, mem_wen=0, mem_a/mem_d=head entry; pop at posedge.
  - Accepted requests have priority over drain.
- **Idle strobes:** mem_cen=1 and mem_wen=1 whenever there is no RD or drain access.
- **Reset (asserted at any time):**
  - Buffer contents are discarded and unwritten stores are lost.
  - State→IDLE and any in-flight load is dropped with no resp_valid.
  - Reset values: resp_valid=0, resp_rdata=0, misalign=0, sb_empty=1, mem_cen=1, mem_wen=1, mem_a=0, mem_d=0, mem_oen=0, req_ready=0.

## Timing
- **Store:** accepted at edge k; earliest SRAM write during cycle k+1 if no request is accepted then.
- **Load hit:** accepted at k; resp_valid in cycle k+1.
- **Load miss:** accepted at k; RD in cycle k+1 (req_ready=0); resp_valid in cycle k+2.
- **Buffer fill:** back-to-back stores at k and k+1 make count=2 and req_ready=0 in cycle k+2. Drain runs in k+2, and req_ready returns in k+3.
- **Store-buffer ordering:** FIFO order. Head/tail pointers wrap modulo SB_DEPTH.
- **Full buffer:** push and pop never occur in the same cycle.
- **Strobe timing:** mem_cen, mem_wen, mem_a and mem_d are stable from shortly after posedge, in time for the SRAM negedge sample. Only mem_cen and mem_wen have a combinational path (from req_valid, through the drain condition).

## Structure
- **Package dmem_pkg:**
  - state enum {IDLE, RD}
  - AW default
  - function word_idx(addr)
  - store-buffer entry struct {idx, data}
- **Sub-module dmem_store_buffer:** SB_DEPTH FIFO.
  - Ports: push, pop, head entry, count.
  - Combinational youngest-match lookup returning hit and data.

## Test plan
1. **Load miss:** SRAM init mem[0]=15, mem[1]=20; reset; load addr 0 then addr 4 → resp_rdata 15 then 20, each resp_valid at k+2; mem_cen low for exactly one cycle per load with mem_a 0 then 1.
2. **Store forwarding:** store 30 to addr 16, next cycle load addr 16 → forwarded 30 at k+1, no RD read of word 4; buffer drains with mem_a=4, mem_d=30; later reload after sb_empty returns 30 via RD.
3. **Youngest match and full:** stores 30 then 40 to addr 16 back-to-back → req_ready=0 one cycle (full); load addr 16 → 40; SRAM word 4 ends at 40 after two drains in order.
4. **Misaligned load:** load addr 2 → misalign and resp_valid pulse with rdata 0, mem_cen stays 1. A misaligned store likewise leaves the buffer unchanged.
5. **Arbitration:** stores to words 2 and 3, then continuous load requests → no drain while requests are accepted; drains occur only in gap cycles, order word 2 then word 3.
6. **Reset mid-operation:** store 99 to addr 8, assert rst before the drain → all outputs at reset values, no SRAM write; post-reset load addr 8 returns the original SRAM content.
